// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Default 640x480@60 raster timing constants and a range helper
//                shared by the VGA sync generator and its axis counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int CNT_W    = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit HS_POL   = 1'b0;
  localparam bit VS_POL   = 1'b0;

  // Inclusive unsigned window test on a raster coordinate.
  function automatic logic in_span(input logic [CNT_W-1:0] v,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
//  Module      : vga_axis_counter
//  Description : Enabled modulo-TOTAL counter for one raster axis, with a
//                combinational wrap strobe used to cascade into the next axis.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] c_max = CNT_W'(TOTAL - 1);

  assign wrap = en && (cnt == c_max);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
//  Module      : vga_sync_gen
//  Description : VGA raster timing generator: HSYNC/VSYNC, video_on, pixel
//                coordinates and frame_start, advanced by the PixelCLK enable.
//                Build macro VGA_OUT_REG_EN adds one PixelCLK-enabled output
//                register stage (all outputs lag by one pixel tick).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit HS_POL   = vga_timing_pkg::HS_POL,
  parameter bit VS_POL   = vga_timing_pkg::VS_POL
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PixelCLK,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] c_h_act   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_act   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_hs_lo   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_hs_hi   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] c_vs_lo   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_vs_hi   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if ((c_h_total > (1 << CNT_W)) || (c_v_total > (1 << CNT_W))) begin : g_total_guard
    $error("vga_sync_gen: H/V totals exceed the 10-bit counter range");
  end

  logic [CNT_W-1:0] w_h_cnt, w_v_cnt, w_h_nxt, w_v_nxt;
  logic             w_h_wrap, w_v_wrap;

  vga_axis_counter #(.TOTAL(c_h_total)) u_h_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .en   (PixelCLK),
    .cnt  (w_h_cnt),
    .wrap (w_h_wrap)
  );

  vga_axis_counter #(.TOTAL(c_v_total)) u_v_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .en   (w_h_wrap),
    .cnt  (w_v_cnt),
    .wrap (w_v_wrap)
  );

  // Decode from the values the counters load on this tick so the registered
  // outputs line up with the counters themselves.
  assign w_h_nxt = w_h_wrap ? '0 : w_h_cnt + CNT_W'(1);
  assign w_v_nxt = w_v_wrap ? '0 : (w_h_wrap ? w_v_cnt + CNT_W'(1) : w_v_cnt);

  logic             r_hs, r_vs, r_von, r_fs;
  logic [CNT_W-1:0] r_px, r_py;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_von <= 1'b0;
      r_px  <= '0;
      r_py  <= '0;
      r_fs  <= 1'b0;
    end else begin
      r_fs <= w_v_wrap;
      if (PixelCLK) begin
        r_px  <= w_h_nxt;
        r_py  <= w_v_nxt;
        r_von <= (w_h_nxt < c_h_act) && (w_v_nxt < c_v_act);
        r_hs  <= in_span(w_h_nxt, c_hs_lo, c_hs_hi) ? HS_POL : ~HS_POL;
        r_vs  <= in_span(w_v_nxt, c_vs_lo, c_vs_hi) ? VS_POL : ~VS_POL;
      end
    end
  end

`ifdef VGA_OUT_REG_EN
  logic             r_hs_q, r_vs_q, r_von_q, r_fs_q, r_fs_pend;
  logic [CNT_W-1:0] r_px_q, r_py_q;
  logic             w_fs_arm;

  // A frame pulse waits here until the next pixel tick releases it.
  assign w_fs_arm = r_fs | r_fs_pend;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hs_q    <= ~HS_POL;
      r_vs_q    <= ~VS_POL;
      r_von_q   <= 1'b0;
      r_px_q    <= '0;
      r_py_q    <= '0;
      r_fs_q    <= 1'b0;
      r_fs_pend <= 1'b0;
    end else begin
      r_fs_q    <= PixelCLK & w_fs_arm;
      r_fs_pend <= w_fs_arm & ~PixelCLK;
      if (PixelCLK) begin
        r_hs_q  <= r_hs;
        r_vs_q  <= r_vs;
        r_von_q <= r_von;
        r_px_q  <= r_px;
        r_py_q  <= r_py;
      end
    end
  end

  assign HSYNC       = r_hs_q;
  assign VSYNC       = r_vs_q;
  assign video_on    = r_von_q;
  assign pixel_x     = r_px_q;
  assign pixel_y     = r_py_q;
  assign frame_start = r_fs_q;
`else
  assign HSYNC       = r_hs;
  assign VSYNC       = r_vs;
  assign video_on    = r_von;
  assign pixel_x     = r_px;
  assign pixel_y     = r_py;
  assign frame_start = r_fs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Self-checking bench for vga_sync_gen: default 640x480 timing
//                plus a reduced-raster instance so whole frames fit in the run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

`ifdef VGA_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pclk;
  logic       hs_d, vs_d, von_d, fs_d;
  logic [9:0] px_d, py_d;
  logic       hs_s, vs_s, von_s, fs_s;
  logic [9:0] px_s, py_s;

  int vectors = 0;
  int errors  = 0;
  int t       = 0;
  bit last_tick = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .CLK(clk), .RST(rst), .PixelCLK(pclk),
    .HSYNC(hs_d), .VSYNC(vs_d), .video_on(von_d),
    .pixel_x(px_d), .pixel_y(py_d), .frame_start(fs_d)
  );

  // Small raster: 32 ticks per line, 13 lines per frame, active-high HSYNC.
  vga_sync_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_s (
    .CLK(clk), .RST(rst), .PixelCLK(pclk),
    .HSYNC(hs_s), .VSYNC(vs_s), .video_on(von_s),
    .pixel_x(px_s), .pixel_y(py_s), .frame_start(fs_s)
  );

  // Reference: position is simply the tick count split into line/frame.
  function automatic logic [23:0] model(input int e, input bit tk,
                                        input int ha, input int hf, input int hw, input int hb,
                                        input int va, input int vf, input int vw, input int vb,
                                        input bit hp, input bit vp);
    int ht, vt, x, y;
    logic hs, vs, von, fs;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    fs = tk && (e >= 1) && ((e % (ht * vt)) == 0);
    if (e <= 0) return {10'd0, 10'd0, ~hp, ~vp, 1'b0, fs};
    x   = e % ht;
    y   = (e / ht) % vt;
    hs  = (x >= ha + hf && x < ha + hf + hw) ? hp : ~hp;
    vs  = (y >= va + vf && y < va + vf + vw) ? vp : ~vp;
    von = (x < ha) && (y < va);
    return {10'(x), 10'(y), hs, vs, von, fs};
  endfunction

  task automatic check_vec(input string name, input logic [23:0] got, input logic [23:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
    end
  endtask

  task automatic check_all();
    check_vec("default", {px_d, py_d, hs_d, vs_d, von_d, fs_d},
              model(t - LAT, last_tick, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    check_vec("small", {px_s, py_s, hs_s, vs_s, von_s, fs_s},
              model(t - LAT, last_tick, 20, 3, 4, 5, 6, 2, 2, 3, 1'b1, 1'b0));
  endtask

  task automatic cyc(input bit pe);
    pclk = pe;
    @(posedge clk);
    last_tick = pe && !rst;
    if (rst) t = 0;
    else if (pe) t++;
    #1;
    check_all();
  endtask

  typedef struct {
    int         tk;
    logic [9:0] x, y;
    logic       hs, vs, von;
  } vec_t;

  vec_t tbl[13];
  int   pulses;

  initial begin
    tbl[0]  = '{1,    10'd1,   10'd0,  1'b1, 1'b1, 1'b1};
    tbl[1]  = '{639,  10'd639, 10'd0,  1'b1, 1'b1, 1'b1};
    tbl[2]  = '{640,  10'd640, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{655,  10'd655, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[4]  = '{656,  10'd656, 10'd0,  1'b0, 1'b1, 1'b0};
    tbl[5]  = '{751,  10'd751, 10'd0,  1'b0, 1'b1, 1'b0};
    tbl[6]  = '{752,  10'd752, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[7]  = '{799,  10'd799, 10'd0,  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{800,  10'd0,   10'd1,  1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1456, 10'd656, 10'd1,  1'b0, 1'b1, 1'b0};
    tbl[10] = '{8640, 10'd640, 10'd10, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{8799, 10'd799, 10'd10, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{8800, 10'd0,   10'd11, 1'b1, 1'b1, 1'b1};

    rst  = 1'b1;
    pclk = 1'b0;
    #1;
    check_all();
    cyc(1); cyc(1);
    rst = 1'b0;

    // Hand-derived checkpoints on the default raster, PixelCLK held high.
    foreach (tbl[i]) begin
      for (int k = 0; k < 20000 && t < tbl[i].tk + LAT; k++) cyc(1);
      check_vec($sformatf("table%0d", i), {px_d, py_d, hs_d, vs_d, von_d},
                {tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].von});
    end

    // Asynchronous reset mid-frame takes effect before the next edge.
    for (int k = 0; k < 37; k++) cyc(1);
    #2 rst = 1'b1;
    t = 0;
    last_tick = 1'b0;
    #1;
    check_all();
    check_vec("async_rst_sync", {hs_d, vs_d, hs_s, vs_s}, 4'b1101);
    cyc(1); cyc(1);
    rst = 1'b0;
    cyc(1);
    check_vec("first_tick", {px_d, py_d, fs_d}, {(LAT == 0) ? 10'd1 : 10'd0, 10'd0, 1'b0});

    // Randomly gapped pixel ticks.
    for (int k = 0; k < 6000; k++) cyc($urandom_range(0, 2) != 0);

    // Divisor at 1:4: one tick every fourth CLK, outputs hold in between.
    for (int k = 0; k < 2000; k++) cyc((k % 4) == 0);

    // Two complete small frames from reset give exactly two frame_start pulses.
    rst = 1'b1;
    cyc(0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 2 * 416 + 5; k++) begin
      cyc(1);
      if (fs_s) pulses++;
    end
    check_vec("frame_pulses", 24'(pulses), 24'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0d got=timeout expected=finish", t);
    $fatal(1);
  end

endmodule

`default_nettype wire
